// File: rtl/axi4lite_mp_ram_pkg.sv
// Shared types for the multi-port AXI4-lite RAM: response codes and port index.
package axi4lite_mp_ram_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  // Wide enough for the largest supported port count (8).
  typedef logic [2:0] port_idx_t;

endpackage

// File: rtl/mpram_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority moves to the port after the winner.
module mpram_rr_arbiter
  import axi4lite_mp_ram_pkg::*;
#(
  parameter int unsigned NB_REQ = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NB_REQ-1:0] req,
  output logic [NB_REQ-1:0] grant
);

  port_idx_t ptr;
  port_idx_t win;
  logic      any;

  // Scan from the priority pointer outward; the first requester found wins.
  always_comb begin
    grant = '0;
    win   = ptr;
    any   = 1'b0;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      for (int unsigned i = 0; i < NB_REQ; i++) begin
        if (!any && req[i] && (i == (32'(ptr) + k) % NB_REQ)) begin
          grant[i] = 1'b1;
          win      = port_idx_t'(i);
          any      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (win == port_idx_t'(NB_REQ - 1)) ? '0 : port_idx_t'(win + 1'b1);
    end
  end

endmodule

// File: rtl/axi4lite_mp_ram.sv
// Multi-port AXI4-lite RAM: round-robin arbitrated write ports, independent read ports.
// Build option: define AXI4LITE_MP_RAM_WSTRB_EN to honour wstrb byte enables.
module axi4lite_mp_ram
  import axi4lite_mp_ram_pkg::*;
#(
  parameter int unsigned NB_WPORT   = 2,
  parameter int unsigned NB_RPORT   = 2,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NB_WPORT-1:0]              awvalid,
  output logic [NB_WPORT-1:0]              awready,
  input  logic [NB_WPORT*ADDR_WIDTH-1:0]   awaddr,
  input  logic [NB_WPORT*3-1:0]            awprot,
  input  logic [NB_WPORT-1:0]              wvalid,
  output logic [NB_WPORT-1:0]              wready,
  input  logic [NB_WPORT*DATA_WIDTH-1:0]   wdata,
  input  logic [NB_WPORT*DATA_WIDTH/8-1:0] wstrb,
  output logic [NB_WPORT-1:0]              bvalid,
  input  logic [NB_WPORT-1:0]              bready,
  output logic [NB_WPORT*2-1:0]            bresp,
  input  logic [NB_RPORT-1:0]              arvalid,
  output logic [NB_RPORT-1:0]              arready,
  input  logic [NB_RPORT*ADDR_WIDTH-1:0]   araddr,
  input  logic [NB_RPORT*3-1:0]            arprot,
  output logic [NB_RPORT-1:0]              rvalid,
  input  logic [NB_RPORT-1:0]              rready,
  output logic [NB_RPORT*DATA_WIDTH-1:0]   rdata,
  output logic [NB_RPORT*2-1:0]            rresp
);

  localparam int unsigned         NB_STRB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  logic                  run;
  logic [NB_WPORT-1:0]   aw_full, w_full, b_valid, wr_req, wr_gnt;
  logic [ADDR_WIDTH-1:0] aw_addr [NB_WPORT];
  logic [DATA_WIDTH-1:0] w_data  [NB_WPORT];
  logic [NB_STRB-1:0]    w_strb  [NB_WPORT];
  resp_e                 b_resp  [NB_WPORT];
  logic [NB_RPORT-1:0]   r_valid;
  logic [DATA_WIDTH-1:0] r_data  [NB_RPORT];
  resp_e                 r_resp  [NB_RPORT];
  logic [DATA_WIDTH-1:0] mem     [RAM_DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB_STRB-1:0]    wr_strb;
  logic                  unused_ok;

  mpram_rr_arbiter #(.NB_REQ(NB_WPORT)) u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (wr_req),
    .grant   (wr_gnt)
  );

  // run keeps every ready low while in reset and until the first edge after release.
  for (genvar i = 0; i < NB_WPORT; i++) begin : g_wport
    assign awready[i]        = run & ~aw_full[i];
    assign wready[i]         = run & ~w_full[i];
    assign wr_req[i]         = aw_full[i] & w_full[i] & ~b_valid[i];
    assign bresp[2*i +: 2]   = b_resp[i];
  end
  assign bvalid = b_valid;

  for (genvar j = 0; j < NB_RPORT; j++) begin : g_rport
    assign arready[j]                     = run & ~r_valid[j];
    assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = r_data[j];
    assign rresp[2*j +: 2]                = r_resp[j];
  end
  assign rvalid = r_valid;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_strb = '0;
    for (int unsigned i = 0; i < NB_WPORT; i++) begin
      if (wr_gnt[i]) begin
        wr_en   = in_range(aw_addr[i]);
        wr_addr = aw_addr[i];
        wr_data = w_data[i];
        wr_strb = w_strb[i];
      end
    end
  end

  // Memory has no reset; a grant cannot exist during reset, so pending writes are dropped.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
`ifdef AXI4LITE_MP_RAM_WSTRB_EN
      for (int unsigned b = 0; b < NB_STRB; b++) begin
        if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
`else
      mem[wr_addr] <= wr_data;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run     <= 1'b0;
      aw_full <= '0;
      w_full  <= '0;
      b_valid <= '0;
      r_valid <= '0;
      for (int unsigned i = 0; i < NB_WPORT; i++) begin
        aw_addr[i] <= '0;
        w_data[i]  <= '0;
        w_strb[i]  <= '0;
        b_resp[i]  <= OKAY;
      end
      for (int unsigned j = 0; j < NB_RPORT; j++) begin
        r_data[j] <= '0;
        r_resp[j] <= OKAY;
      end
    end else begin
      run <= 1'b1;
      for (int unsigned i = 0; i < NB_WPORT; i++) begin
        if (b_valid[i] && bready[i]) begin
          aw_full[i] <= 1'b0;
          w_full[i]  <= 1'b0;
          b_valid[i] <= 1'b0;
        end else begin
          if (awvalid[i] && awready[i]) begin
            aw_full[i] <= 1'b1;
            aw_addr[i] <= awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
          end
          if (wvalid[i] && wready[i]) begin
            w_full[i] <= 1'b1;
            w_data[i] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_strb[i] <= wstrb[i*NB_STRB +: NB_STRB];
          end
          if (wr_gnt[i]) begin
            b_valid[i] <= 1'b1;
            b_resp[i]  <= in_range(aw_addr[i]) ? OKAY : SLVERR;
          end
        end
      end
      for (int unsigned j = 0; j < NB_RPORT; j++) begin
        if (arvalid[j] && arready[j]) begin
          r_valid[j] <= 1'b1;
          r_data[j]  <= in_range(araddr[j*ADDR_WIDTH +: ADDR_WIDTH]) ?
                        mem[araddr[j*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
          r_resp[j]  <= in_range(araddr[j*ADDR_WIDTH +: ADDR_WIDTH]) ? OKAY : SLVERR;
        end else if (r_valid[j] && rready[j]) begin
          r_valid[j] <= 1'b0;
        end
      end
    end
  end

`ifdef AXI4LITE_MP_RAM_WSTRB_EN
  assign unused_ok = ^{awprot, arprot};
`else
  assign unused_ok = ^{awprot, arprot, wr_strb};
`endif

endmodule

// File: tb/tb_axi4lite_mp_ram.sv
// Self-checking bench for axi4lite_mp_ram (2W/2R, depth 6) against a word-level memory model.
module tb_axi4lite_mp_ram;

`ifdef AXI4LITE_MP_RAM_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif
  localparam int DEPTH = 6;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  arvalid, arready, rvalid, rready;
  logic [5:0]  awaddr, araddr, awprot, arprot;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [3:0]  bresp, rresp;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  int          prio = 0;

  always #5 aclk = ~aclk;

  axi4lite_mp_ram #(
    .NB_WPORT(2), .NB_RPORT(2), .ADDR_WIDTH(3), .RAM_DEPTH(6), .DATA_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b] || !STRB_EN) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input int p, input int a, input logic [31:0] d,
                             input logic [3:0] s);
    if (a < DEPTH) model[a] = merge(model[a], d, s);
    prio = (p + 1) % 2;
  endtask

  task automatic send_aw(input int p, input logic [2:0] a);
    int t = 0;
    while (awready[p] !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    awvalid[p] = 1'b1; awaddr[p*3 +: 3] = a;
    @(negedge aclk);
    awvalid[p] = 1'b0;
  endtask

  task automatic send_w(input int p, input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    while (wready[p] !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    wvalid[p] = 1'b1; wdata[p*32 +: 32] = d; wstrb[p*4 +: 4] = s;
    @(negedge aclk);
    wvalid[p] = 1'b0;
  endtask

  task automatic wait_b(input int p, output int lat, output logic [1:0] resp);
    lat = 0;
    while (bvalid[p] !== 1'b1 && lat < 50) begin @(negedge aclk); lat++; end
    resp = bresp[p*2 +: 2];
    bready[p] = 1'b1;
    @(negedge aclk);
    bready[p] = 1'b0;
  endtask

  task automatic write_word(input int p, input logic [2:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit w_first,
                            output int lat, output logic [1:0] resp);
    if (w_first) begin send_w(p, d, s); send_aw(p, a); end
    else begin send_aw(p, a); send_w(p, d, s); end
    wait_b(p, lat, resp);
  endtask

  task automatic do_read(input int p, input logic [2:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int t = 0;
    while (arready[p] !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    arvalid[p] = 1'b1; araddr[p*3 +: 3] = a;
    @(negedge aclk);
    arvalid[p] = 1'b0;
    lat = 0;
    while (rvalid[p] !== 1'b1 && lat < 50) begin @(negedge aclk); lat++; end
    d = rdata[p*32 +: 32];
    resp = rresp[p*2 +: 2];
    rready[p] = 1'b1;
    @(negedge aclk);
    rready[p] = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 18'h0 || rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%h rdata=%h want 0", {awready, wready, bvalid, arready, rvalid, bresp, rresp}, rdata);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if ({awready, wready, arready} !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 111111", {awready, wready, arready});
    end
  endtask

  task automatic test_init();
    int lat; logic [1:0] resp; logic [31:0] d;
    for (int a = 0; a < DEPTH; a++) begin
      d = $urandom;
      write_word(0, 3'(a), d, 4'hF, 1'b0, lat, resp);
      model_write(0, a, d, 4'hF);
      n_checks++;
      if (resp !== 2'b00 || lat !== 1) begin
        n_fail++;
        $display("FAIL init_write a=%0d: resp=%b lat=%0d want 00/1", a, resp, lat);
      end
    end
  endtask

  task automatic test_order();
    int lat; logic [1:0] resp; logic [31:0] d;
    send_w(1, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (wready[1] !== 1'b0) begin n_fail++; $display("FAIL order_wready: got %b want 0", wready[1]); end
    repeat (3) begin
      n_checks++;
      if (bvalid[1] !== 1'b0) begin n_fail++; $display("FAIL order_no_early_b: got %b want 0", bvalid[1]); end
      @(negedge aclk);
    end
    send_aw(1, 3'd2);
    wait_b(1, lat, resp);
    model_write(1, 2, 32'hDEADBEEF, 4'hF);
    n_checks++;
    if (lat !== 1 || resp !== 2'b00) begin
      n_fail++; $display("FAIL order_b: lat=%0d resp=%b want 1/00", lat, resp);
    end
    do_read(0, 3'd2, d, resp, lat);
    n_checks++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00 || lat !== 0) begin
      n_fail++; $display("FAIL order_read: d=%h resp=%b lat=%0d want deadbeef/00/0", d, resp, lat);
    end
  endtask

  task automatic contention_round(input logic [31:0] d0, input logic [31:0] d1);
    int first, second, lat; logic [1:0] resp; logic [31:0] d;
    logic [31:0] dd [2];
    dd[0] = d0; dd[1] = d1;
    first = prio; second = 1 - prio;
    awvalid = 2'b11; wvalid = 2'b11; awaddr = {3'd5, 3'd5}; wdata = {d1, d0}; wstrb = 8'hFF;
    @(negedge aclk);
    awvalid = '0; wvalid = '0;
    n_checks++;
    if (bvalid !== 2'b00) begin n_fail++; $display("FAIL cont_b0: got %b want 00", bvalid); end
    @(negedge aclk);
    n_checks++;
    if (bvalid !== (2'b01 << first)) begin
      n_fail++; $display("FAIL cont_first: got %b want %b", bvalid, 2'b01 << first);
    end
    @(negedge aclk);
    n_checks++;
    if (bvalid !== 2'b11 || bresp !== 4'b0) begin
      n_fail++; $display("FAIL cont_second: bvalid=%b bresp=%b want 11/0000", bvalid, bresp);
    end
    bready = 2'b11;
    @(negedge aclk);
    bready = 2'b00;
    model_write(first, 5, dd[first], 4'hF);
    model_write(second, 5, dd[second], 4'hF);
    do_read(1, 3'd5, d, resp, lat);
    n_checks++;
    if (d !== model[5] || resp !== 2'b00) begin
      n_fail++; $display("FAIL cont_read: d=%h resp=%b want %h/00", d, resp, model[5]);
    end
  endtask

  task automatic test_contention();
    int lat; logic [1:0] resp; logic [31:0] d;
    contention_round(32'h11111111, 32'h22222222);
    d = $urandom;
    write_word(0, 3'd0, d, 4'hF, 1'b1, lat, resp);
    model_write(0, 0, d, 4'hF);
    contention_round($urandom, $urandom);
  endtask

  task automatic test_out_of_range();
    int lat; logic [1:0] resp; logic [31:0] d;
    write_word(0, 3'd7, $urandom, 4'hF, 1'b0, lat, resp);
    model_write(0, 7, 32'h0, 4'hF);
    n_checks++;
    if (resp !== 2'b10 || lat !== 1) begin
      n_fail++; $display("FAIL oor_write: resp=%b lat=%0d want 10/1", resp, lat);
    end
    do_read(1, 3'd6, d, resp, lat);
    n_checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      n_fail++; $display("FAIL oor_read6: d=%h resp=%b want 0/10", d, resp);
    end
    do_read(0, 3'd7, d, resp, lat);
    n_checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      n_fail++; $display("FAIL oor_read7: d=%h resp=%b want 0/10", d, resp);
    end
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a % 2, 3'(a), d, resp, lat);
      n_checks++;
      if (d !== model[a] || resp !== 2'b00) begin
        n_fail++; $display("FAIL oor_unchanged a=%0d: d=%h want %h", a, d, model[a]);
      end
    end
  endtask

  task automatic test_byte_enable();
    int lat; logic [1:0] resp; logic [31:0] d;
    write_word(1, 3'd1, 32'hAABBCCDD, 4'hF, 1'b0, lat, resp);
    model_write(1, 1, 32'hAABBCCDD, 4'hF);
    write_word(1, 3'd1, 32'h11223344, 4'b0101, 1'b0, lat, resp);
    model_write(1, 1, 32'h11223344, 4'b0101);
    do_read(0, 3'd1, d, resp, lat);
    n_checks++;
    if (d !== (STRB_EN ? 32'hAA22CC44 : 32'h11223344) || d !== model[1]) begin
      n_fail++; $display("FAIL byte_enable: got %h want %h", d, model[1]);
    end
  endtask

  task automatic test_backpressure();
    arvalid[1] = 1'b1; araddr[5:3] = 3'd2;
    @(negedge aclk);
    arvalid[1] = 1'b0;
    repeat (5) begin
      n_checks++;
      if (rvalid[1] !== 1'b1 || rdata[63:32] !== model[2] || arready[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold: rvalid=%b rdata=%h arready=%b want 1/%h/0", rvalid[1], rdata[63:32], arready[1], model[2]);
      end
      @(negedge aclk);
    end
    rready[1] = 1'b1;
    @(negedge aclk);
    rready[1] = 1'b0;
    n_checks++;
    if (arready[1] !== 1'b1 || rvalid[1] !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: arready=%b rvalid=%b want 1/0", arready[1], rvalid[1]);
    end
  endtask

  task automatic test_collision();
    int lat; logic [1:0] resp; logic [31:0] d, old, nd;
    old = model[3]; nd = ~old;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; awaddr[2:0] = 3'd3; wdata[31:0] = nd; wstrb[3:0] = 4'hF;
    @(negedge aclk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    arvalid[1] = 1'b1; araddr[5:3] = 3'd3;
    @(negedge aclk);
    arvalid[1] = 1'b0;
    n_checks++;
    if (bvalid[0] !== 1'b1 || rvalid[1] !== 1'b1 || rdata[63:32] !== old) begin
      n_fail++;
      $display("FAIL collision_old: bvalid=%b rvalid=%b rdata=%h want 1/1/%h", bvalid[0], rvalid[1], rdata[63:32], old);
    end
    rready[1] = 1'b1; bready[0] = 1'b1;
    @(negedge aclk);
    rready[1] = 1'b0; bready[0] = 1'b0;
    model_write(0, 3, nd, 4'hF);
    do_read(0, 3'd3, d, resp, lat);
    n_checks++;
    if (d !== model[3]) begin n_fail++; $display("FAIL collision_new: got %h want %h", d, model[3]); end
  endtask

  task automatic test_random();
    int p, a, rp, lat; logic [1:0] resp; logic [31:0] d, rd; logic [3:0] s;
    for (int n = 0; n < 16; n++) begin
      p = $urandom_range(0, 1); a = $urandom_range(0, 7); rp = $urandom_range(0, 1);
      d = $urandom; s = 4'($urandom_range(0, 15));
      write_word(p, 3'(a), d, s, 1'($urandom_range(0, 1)), lat, resp);
      model_write(p, a, d, s);
      n_checks++;
      if (resp !== (a < DEPTH ? 2'b00 : 2'b10) || lat !== 1) begin
        n_fail++; $display("FAIL rand_write n=%0d a=%0d: resp=%b lat=%0d", n, a, resp, lat);
      end
      do_read(rp, 3'(a), rd, resp, lat);
      n_checks++;
      if (rd !== (a < DEPTH ? model[a] : 32'h0) || resp !== (a < DEPTH ? 2'b00 : 2'b10) || lat !== 0) begin
        n_fail++;
        $display("FAIL rand_read n=%0d a=%0d: d=%h resp=%b lat=%0d want %h", n, a, rd, resp, lat, (a < DEPTH ? model[a] : 32'h0));
      end
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [1:0] resp; logic [31:0] d;
    send_aw(0, 3'd4);
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 18'h0 || rdata !== 64'h0) begin
      n_fail++; $display("FAIL midop_reset_outputs: got ctl=%h rdata=%h want 0", {awready, wready, bvalid, arready, rvalid, bresp, rresp}, rdata);
    end
    prio = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++;
    if (awready !== 2'b11) begin n_fail++; $display("FAIL midop_awready: got %b want 11", awready); end
    send_w(0, ~model[4], 4'hF);
    repeat (6) begin
      n_checks++;
      if (bvalid !== 2'b00) begin n_fail++; $display("FAIL midop_no_b: got %b want 00", bvalid); end
      @(negedge aclk);
    end
    do_read(1, 3'd4, d, resp, lat);
    n_checks++;
    if (d !== model[4]) begin n_fail++; $display("FAIL midop_mem: got %h want %h", d, model[4]); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_order();
    test_contention();
    test_out_of_range();
    test_byte_enable();
    test_backpressure();
    test_collision();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
